// File: rtl/prog_loader_arb.sv
// Program-load / CPU RAM port arbiter: IDLE, LOAD (host owns RAM) and RUN (CPU owns RAM).
// Latency: zero; RAM strobes and read data are combinational from state and inputs.
// Backpressure: host_ready is high for every LOAD cycle, so host beats are never stalled.
module prog_loader_arb #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_req,
  input  logic          host_valid,
  input  logic [DW-1:0] host_data,
  input  logic          host_last,
  output logic          host_ready,
  output logic          load_gnt,
  input  logic          run_req,
  output logic          cpu_start,
  input  logic [AW-1:0] cpu_addr,
  input  logic          cpu_we,
  input  logic [DW-1:0] cpu_wdata,
  output logic [DW-1:0] cpu_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_we,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic [AW:0]   load_count,
  output logic          load_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2
  } state_t;

  localparam logic [AW-1:0] WPTR_MAX = '1;

  state_t        state, state_nxt;
  logic [AW-1:0] wptr, wptr_nxt;
  logic [AW:0]   load_count_nxt;
  logic          load_err_nxt;
  logic          pend, pend_nxt;
  logic          beat, last_beat;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      wptr       <= '0;
      load_count <= '0;
      load_err   <= 1'b0;
      pend       <= 1'b0;
    end else begin
      state      <= state_nxt;
      wptr       <= wptr_nxt;
      load_count <= load_count_nxt;
      load_err   <= load_err_nxt;
      pend       <= pend_nxt;
    end
  end

  assign cpu_rdata = ram_rdata;

  always_comb begin
    state_nxt      = state;
    wptr_nxt       = wptr;
    load_count_nxt = load_count;
    load_err_nxt   = load_err;
    pend_nxt       = pend;
    beat           = (state == LOAD) && host_valid;
    last_beat      = beat && (host_last || (wptr == WPTR_MAX));
    load_gnt       = (state == LOAD);
    host_ready     = (state == LOAD);
    cpu_start      = (state == RUN);
    ram_addr       = cpu_addr;
    ram_wdata      = cpu_wdata;
    ram_we         = 1'b0;

    case (state)
      IDLE: begin
        // A load requested while the CPU was running is honoured here even if the level has since dropped.
        if (load_req || pend) begin
          state_nxt    = LOAD;
          wptr_nxt     = '0;
          load_err_nxt = 1'b0;
          pend_nxt     = 1'b0;
        end else if (run_req) begin
          state_nxt = RUN;
        end
      end
      LOAD: begin
        ram_addr  = wptr;
        ram_wdata = host_data;
        ram_we    = host_valid;
        if (!load_req) begin
          state_nxt      = IDLE;
          load_err_nxt   = 1'b1;
          load_count_nxt = {1'b0, wptr} + (AW+1)'(beat);
        end else if (last_beat) begin
          state_nxt      = IDLE;
          load_count_nxt = {1'b0, wptr} + (AW+1)'(1);
        end else if (beat) begin
          wptr_nxt = wptr + AW'(1);
        end
      end
      RUN: begin
        ram_we = cpu_we;
        if (load_req) pend_nxt = 1'b1;
        if (!run_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader_arb.sv
// Bench for prog_loader_arb: directed scenarios with literal expectations, then random traffic
// checked every cycle against a mode/counter model and an expected RAM image.
module tb_prog_loader_arb;
  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          load_req, host_valid, host_last, run_req, cpu_we;
  logic [DW-1:0] host_data, cpu_wdata;
  logic [AW-1:0] cpu_addr;
  logic          host_ready, load_gnt, cpu_start, ram_we, load_err;
  logic [DW-1:0] cpu_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_addr;
  logic [AW:0]   load_count;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  prog_loader_arb #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset),
    .load_req(load_req), .host_valid(host_valid), .host_data(host_data),
    .host_last(host_last), .host_ready(host_ready), .load_gnt(load_gnt),
    .run_req(run_req), .cpu_start(cpu_start),
    .cpu_addr(cpu_addr), .cpu_we(cpu_we), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .load_count(load_count), .load_err(load_err)
  );

  // RAM attached to the arbiter: synchronous write, asynchronous read.
  logic          init_mem = 1'b1;
  logic [DW-1:0] tb_mem [16];
  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= 8'(i * 7 + 3);
    end else if (ram_we) begin
      tb_mem[ram_addr] <= ram_wdata;
    end
  end
  assign ram_rdata = tb_mem[ram_addr];

  // Model: mode 0 = idle, 1 = host loading, 2 = cpu running.
  int m_mode, m_wp, m_cnt, m_err, m_pend;
  int exp_mem [16];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_wp = 0; m_cnt = 0; m_err = 0; m_pend = 0;
  endtask

  task automatic model_step();
    int beat;
    int n;
    if (!reset) begin
      model_reset();
      return;
    end
    case (m_mode)
      0: begin
        if (load_req || m_pend != 0) begin
          m_mode = 1; m_wp = 0; m_err = 0; m_pend = 0;
        end else if (run_req) begin
          m_mode = 2;
        end
      end
      1: begin
        beat = int'(host_valid);
        n = m_wp + beat;
        if (beat != 0) exp_mem[m_wp] = int'(host_data);
        if (!load_req) begin
          m_mode = 0; m_err = 1; m_cnt = n;
        end else if (beat != 0 && (host_last || m_wp == 15)) begin
          m_mode = 0; m_cnt = n;
        end else begin
          m_wp = n;
        end
      end
      default: begin
        if (cpu_we) exp_mem[cpu_addr] = int'(cpu_wdata);
        if (load_req) m_pend = 1;
        if (!run_req) m_mode = 0;
      end
    endcase
  endtask

  task automatic check_outputs();
    int e_addr;
    int e_we;
    if (!reset) model_reset();
    e_addr = (m_mode == 1) ? m_wp : int'(cpu_addr);
    e_we   = ((m_mode == 1 && host_valid) || (m_mode == 2 && cpu_we)) ? 1 : 0;
    chk("host_ready", int'(host_ready), m_mode == 1 ? 1 : 0);
    chk("load_gnt", int'(load_gnt), m_mode == 1 ? 1 : 0);
    chk("cpu_start", int'(cpu_start), m_mode == 2 ? 1 : 0);
    chk("ram_we", int'(ram_we), e_we);
    chk("ram_addr", int'(ram_addr), e_addr);
    chk("ram_wdata", int'(ram_wdata), m_mode == 1 ? int'(host_data) : int'(cpu_wdata));
    chk("cpu_rdata", int'(cpu_rdata), exp_mem[e_addr]);
    chk("load_count", int'(load_count), m_cnt);
    chk("load_err", int'(load_err), m_err);
  endtask

  task automatic cyc();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_step();
    #1;
  endtask

  initial begin
    load_req = 0; host_valid = 0; host_data = '0; host_last = 0;
    run_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    for (int i = 0; i < 16; i++) exp_mem[i] = (i * 7 + 3) & 8'hFF;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    init_mem = 1'b0;
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_load_gnt", int'(load_gnt), 0);
    chk("rst_host_ready", int'(host_ready), 0);
    chk("rst_cpu_start", int'(cpu_start), 0);
    chk("rst_load_count", int'(load_count), 0);
    chk("rst_load_err", int'(load_err), 0);
    reset = 1'b1;
    cyc();

    // Full 16-byte load without host_last.
    load_req = 1; cyc();
    chk("full_gnt", int'(load_gnt), 1);
    for (int i = 0; i < 16; i++) begin
      host_valid = 1; host_data = 8'(16 + i); cyc();
    end
    host_valid = 0; load_req = 0;
    chk("full_gnt_drop", int'(load_gnt), 0);
    chk("full_count", int'(load_count), 16);
    chk("full_err", int'(load_err), 0);
    for (int i = 0; i < 16; i++) chk("full_mem", int'(tb_mem[i]), 16 + i);
    cyc();

    // Short load ended by host_last on the third byte.
    load_req = 1; cyc();
    for (int i = 0; i < 3; i++) begin
      host_valid = 1; host_data = 8'(8'hA0 + i); host_last = (i == 2); cyc();
    end
    host_valid = 0; host_last = 0; load_req = 0;
    chk("short_count", int'(load_count), 3);
    chk("short_mem0", int'(tb_mem[0]), 8'hA0);
    chk("short_mem2", int'(tb_mem[2]), 8'hA2);
    chk("short_mem3", int'(tb_mem[3]), 8'h13);
    cyc();

    // Abort after five bytes, then a fresh grant clears the error.
    load_req = 1; cyc();
    for (int i = 0; i < 5; i++) begin
      host_valid = 1; host_data = 8'(8'h50 + i); cyc();
    end
    host_valid = 0; load_req = 0; cyc();
    chk("abort_err", int'(load_err), 1);
    chk("abort_count", int'(load_count), 5);
    load_req = 1; cyc();
    chk("regrant_err", int'(load_err), 0);
    load_req = 0; cyc();

    // CPU write in RUN lands; the same write in IDLE is dropped.
    run_req = 1; cyc();
    chk("run_start", int'(cpu_start), 1);
    cpu_we = 1; cpu_addr = 4'hE; cpu_wdata = 8'h2A; #1;
    chk("run_we", int'(ram_we), 1);
    cyc();
    chk("run_mem14", int'(tb_mem[14]), 8'h2A);
    run_req = 0; cpu_we = 0; cyc();
    chk("idle_start", int'(cpu_start), 0);
    cpu_we = 1; cpu_wdata = 8'h55; #1;
    chk("idle_we", int'(ram_we), 0);
    cyc();
    cpu_we = 0;
    chk("idle_mem14", int'(tb_mem[14]), 8'h2A);

    // Load beats run in IDLE; load request during RUN waits for run_req to drop.
    load_req = 1; run_req = 1; cyc();
    chk("prio_gnt", int'(load_gnt), 1);
    chk("prio_start", int'(cpu_start), 0);
    load_req = 0; run_req = 0; cyc();
    run_req = 1; cyc();
    load_req = 1; cyc(); cyc();
    chk("pend_start", int'(cpu_start), 1);
    chk("pend_gnt", int'(load_gnt), 0);
    load_req = 0; run_req = 0; cyc();
    chk("pend_idle_start", int'(cpu_start), 0);
    chk("pend_idle_gnt", int'(load_gnt), 0);
    cyc();
    chk("pend_load_gnt", int'(load_gnt), 1);
    cyc();

    // Asynchronous reset in the middle of a load at wptr=7.
    load_req = 1; cyc();
    for (int i = 0; i < 7; i++) begin
      host_valid = 1; host_data = 8'(8'h70 + i); cyc();
    end
    host_data = 8'hEE; #1;
    chk("mid_we", int'(ram_we), 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_we", int'(ram_we), 0);
    chk("arst_gnt", int'(load_gnt), 0);
    chk("arst_ready", int'(host_ready), 0);
    chk("arst_count", int'(load_count), 0);
    host_valid = 0; load_req = 0;
    cyc();
    chk("arst_mem7", int'(tb_mem[7]), 8'h17);
    reset = 1'b1;
    cyc();

    // Random traffic.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 9) == 0) load_req = ~load_req;
      if ($urandom_range(0, 7) == 0) run_req = ~run_req;
      host_valid = 1'($urandom_range(0, 1));
      host_last  = ($urandom_range(0, 7) == 0);
      host_data  = 8'($urandom);
      cpu_we     = 1'($urandom_range(0, 1));
      cpu_addr   = 4'($urandom);
      cpu_wdata  = 8'($urandom);
      reset      = ($urandom_range(0, 399) != 0);
      cyc();
    end
    reset = 1'b1; load_req = 0; run_req = 0; cpu_we = 0; host_valid = 0;
    repeat (3) cyc();
    for (int i = 0; i < 16; i++) chk("final_mem", int'(tb_mem[i]), exp_mem[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
